// File: rtl/dma_io_device.sv
// dma_io_device: DMA channel requester/responder with a small byte FIFO.
// Sources bytes on IOR_N or sinks them from IOW_N; ends a block on its own count or on EOP_N_IN.
module dma_io_device #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DIR,
  input  logic              START,
  input  logic [CNT_W-1:0]  XFER_LEN,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic [DATA_W-1:0] DB_IN,
  output logic [DATA_W-1:0] DB_OUT,
  output logic              DB_OE,
  input  logic              EOP_N_IN,
  output logic              EOP_N_OUT,
  input  logic              PUSH_VALID,
  input  logic [DATA_W-1:0] PUSH_DATA,
  output logic              PUSH_READY,
  output logic              POP_VALID,
  output logic [DATA_W-1:0] POP_DATA,
  input  logic              POP_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              TC,
  output logic              ERR
);
  // state    | meaning
  // S_IDLE   | no block in progress
  // S_REQ    | requesting service, DREQ raised when the FIFO allows
  // S_ACK    | DACK held, watching the active strobe for its rising edge
  // S_COMMIT | one cycle: move the byte between FIFO and bus, count down
  // S_DONE   | one-cycle end-of-block pulse

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_COMMIT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               dir_q, dreq_q, tc_q, err_q;
  logic               ior_prev, iow_prev, both_seen, wait_rel;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  cap_q;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [AW+1:0]      occ_local;

  logic full, empty, push_acc, pop_acc, dma_push, dma_pop;
  logic strobe_n, strobe_prev, strobe_rise, both_low, eop_req, last;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign push_acc    = PUSH_VALID && !full;
  assign pop_acc     = POP_READY && !empty;
  assign occ_local   = {1'b0, count} + (AW+2)'(push_acc) - (AW+2)'(pop_acc);
  // DMA side takes the slot behind any same-cycle local traffic
  assign dma_push    = (state == S_COMMIT) && dir_q && (occ_local < (AW+2)'(DEPTH));
  assign dma_pop     = (state == S_COMMIT) && !dir_q && ({1'b0, count} > (AW+2)'(pop_acc));

  assign strobe_n    = dir_q ? IOW_N : IOR_N;
  assign strobe_prev = dir_q ? iow_prev : ior_prev;
  assign strobe_rise = !strobe_prev && strobe_n;
  assign both_low    = DACK && !IOR_N && !IOW_N;
  assign eop_req     = !EOP_N_IN && (state inside {S_REQ, S_ACK, S_COMMIT});
  assign last        = (cnt == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START && XFER_LEN != '0) state_nxt = S_REQ;
      S_REQ: begin
        if (eop_req)                          state_nxt = S_DONE;
        else if (DACK && dreq_q && !wait_rel) state_nxt = S_ACK;
      end
      S_ACK: begin
        if (eop_req)                                          state_nxt = S_DONE;
        else if (!DACK)                                       state_nxt = S_REQ;
        else if (strobe_rise && !both_seen && !both_low)      state_nxt = S_COMMIT;
      end
      S_COMMIT: state_nxt = (last || eop_req) ? S_DONE : S_REQ;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      dir_q     <= 1'b0;
      cnt       <= '0;
      dreq_q    <= 1'b0;
      tc_q      <= 1'b0;
      err_q     <= 1'b0;
      ior_prev  <= 1'b1;
      iow_prev  <= 1'b1;
      both_seen <= 1'b0;
      wait_rel  <= 1'b0;
      cap_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state    <= state_nxt;
      ior_prev <= IOR_N;
      iow_prev <= IOW_N;
      dreq_q   <= (state == S_REQ) && (state_nxt == S_REQ) && !wait_rel && (dir_q ? !full : !empty);
      if (both_low) err_q <= 1'b1;
      case (state)
        S_IDLE: if (START && XFER_LEN != '0) begin
          dir_q    <= DIR;
          cnt      <= XFER_LEN;
          wait_rel <= 1'b0;
        end
        S_REQ: begin
          both_seen <= 1'b0;
          if (!DACK) wait_rel <= 1'b0;
        end
        S_ACK: begin
          if (both_low)         both_seen <= 1'b1;
          else if (strobe_rise) both_seen <= 1'b0;
          if (dir_q && DACK && !IOW_N) cap_q <= DB_IN;
        end
        S_COMMIT: begin
          cnt      <= cnt - CNT_W'(1);
          wait_rel <= 1'b1;
        end
        default: ;
      endcase
      if (state_nxt == S_DONE && state != S_DONE) tc_q <= (state == S_COMMIT) && last;
      wr_ptr <= wr_ptr + AW'(push_acc) + AW'(dma_push);
      rd_ptr <= rd_ptr + AW'(pop_acc) + AW'(dma_pop);
      count  <= count + (AW+1)'(push_acc) + (AW+1)'(dma_push)
                      - (AW+1)'(pop_acc) - (AW+1)'(dma_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_acc) mem[wr_ptr] <= PUSH_DATA;
    if (dma_push) mem[wr_ptr + AW'(push_acc)] <= cap_q;
  end

  assign DREQ       = dreq_q;
  assign DB_OE      = (state == S_ACK) && !dir_q && DACK && !IOR_N;
  assign DB_OUT     = DB_OE ? mem[rd_ptr] : '0;
  assign EOP_N_OUT  = !((state == S_COMMIT) && last);
  assign PUSH_READY = !full;
  assign POP_VALID  = !empty;
  assign POP_DATA   = mem[rd_ptr];
  assign BUSY       = (state != S_IDLE);
  assign DONE       = (state == S_DONE);
  assign TC         = tc_q;
  assign ERR        = err_q;
endmodule

// File: tb/tb_dma_io_device.sv
// Randomized bench for dma_io_device: plays the DMA controller and local FIFO user,
// checking against a queue model of FIFO contents and remaining block count.
module tb_dma_io_device;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic CLK = 1'b0;
  logic RESET, DIR, START, DREQ, DACK, IOR_N, IOW_N, DB_OE, EOP_N_IN, EOP_N_OUT;
  logic PUSH_VALID, PUSH_READY, POP_VALID, POP_READY, BUSY, DONE, TC, ERR;
  logic [CNT_W-1:0]  XFER_LEN;
  logic [DATA_W-1:0] DB_IN, DB_OUT, PUSH_DATA, POP_DATA;

  dma_io_device #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .DIR(DIR), .START(START), .XFER_LEN(XFER_LEN),
    .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .DB_IN(DB_IN),
    .DB_OUT(DB_OUT), .DB_OE(DB_OE), .EOP_N_IN(EOP_N_IN), .EOP_N_OUT(EOP_N_OUT),
    .PUSH_VALID(PUSH_VALID), .PUSH_DATA(PUSH_DATA), .PUSH_READY(PUSH_READY),
    .POP_VALID(POP_VALID), .POP_DATA(POP_DATA), .POP_READY(POP_READY),
    .BUSY(BUSY), .DONE(DONE), .TC(TC), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mq[$];
  int rem = 0;
  bit dir_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    PUSH_VALID = 1'b1;
    PUSH_DATA  = b;
    #1;
    acc = (mq.size() < DEPTH);
    chk("push_ready", 32'(PUSH_READY), 32'(acc));
    step();
    PUSH_VALID = 1'b0;
    if (acc) mq.push_back(b);
  endtask

  task automatic pop_byte();
    logic [7:0] exp_b;
    #1;
    exp_b = (mq.size() != 0) ? mq[0] : 8'h00;
    chk("pop_valid", 32'(POP_VALID), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("pop_data", 32'(POP_DATA), 32'(exp_b));
    POP_READY = 1'b1;
    step();
    POP_READY = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic wait_dreq(input string tag, input int bound);
    int n = 0;
    while (DREQ !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(DREQ), 1);
  endtask

  task automatic start_blk(input bit d, input logic [CNT_W-1:0] len);
    DIR = d;
    XFER_LEN = len;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("start_busy", 32'(BUSY), 32'(len != 0));
    if (len != 0) begin
      dir_m = d;
      rem = int'(len);
    end
  endtask

  // One complete controller transfer: wait DREQ, DACK, strobe pulse, release
  task automatic dma_xfer(input logic [7:0] wdata);
    int hold;
    logic [7:0] exp_b;
    hold = $urandom_range(1, 3);
    wait_dreq("dreq_wait", 40);
    DACK = 1'b1;
    step();
    chk("dreq_drop_in_ack", 32'(DREQ), 0);
    if (!dir_m) begin
      IOR_N = 1'b0;
      #1;
      exp_b = (mq.size() != 0) ? mq[0] : 8'h00;
      chk("db_oe", 32'(DB_OE), 1);
      chk("db_out", 32'(DB_OUT), 32'(exp_b));
    end else begin
      IOW_N = 1'b0;
      DB_IN = wdata;
      #1;
      chk("db_oe_sink", 32'(DB_OE), 0);
    end
    repeat (hold) step();
    IOR_N = 1'b1;
    IOW_N = 1'b1;
    step();
    chk("eop_out", 32'(EOP_N_OUT), 32'(rem != 1));
    rem--;
    if (!dir_m) begin
      if (mq.size() != 0) void'(mq.pop_front());
    end else begin
      mq.push_back(wdata);
    end
    DACK = 1'b0;
    step();
    if (rem == 0) begin
      chk("done_pulse", 32'(DONE), 1);
      chk("tc_own", 32'(TC), 1);
      step();
      chk("done_clear", 32'(DONE), 0);
      chk("busy_end", 32'(BUSY), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dreq"}, 32'(DREQ), 0);
    chk({tag, "_db_oe"}, 32'(DB_OE), 0);
    chk({tag, "_db_out"}, 32'(DB_OUT), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_done"}, 32'(DONE), 0);
    chk({tag, "_tc"}, 32'(TC), 0);
    chk({tag, "_err"}, 32'(ERR), 0);
    chk({tag, "_eop_out"}, 32'(EOP_N_OUT), 1);
    chk({tag, "_pop_valid"}, 32'(POP_VALID), 0);
    chk({tag, "_push_ready"}, 32'(PUSH_READY), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b1;
    bit seen;
    int len;
    bit d;
    RESET = 1'b1; DIR = 1'b0; START = 1'b0; XFER_LEN = '0; DACK = 1'b0;
    IOR_N = 1'b1; IOW_N = 1'b1; DB_IN = '0; EOP_N_IN = 1'b1;
    PUSH_VALID = 1'b0; PUSH_DATA = '0; POP_READY = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    RESET = 1'b0;
    step();

    // source block, three bytes
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    start_blk(1'b0, 16'd3);
    repeat (3) dma_xfer(8'h00);
    chk("src_fifo_empty", 32'(POP_VALID), 0);

    // sink block, two bytes
    start_blk(1'b1, 16'd2);
    dma_xfer(8'hA5);
    dma_xfer(8'h5A);
    pop_byte(); pop_byte();
    chk("sink_fifo_empty", 32'(POP_VALID), 0);

    // sink block longer than the FIFO
    start_blk(1'b1, 16'd10);
    repeat (8) dma_xfer(8'($urandom));
    chk("full_push_ready", 32'(PUSH_READY), 0);
    seen = 1'b0;
    repeat (8) begin
      step();
      if (DREQ) seen = 1'b1;
    end
    chk("dreq_held_full", 32'(seen), 0);
    pop_byte();
    step();
    chk("dreq_after_pop", 32'(DREQ), 1);
    dma_xfer(8'($urandom));
    pop_byte();
    dma_xfer(8'($urandom));
    repeat (8) pop_byte();
    chk("long_fifo_empty", 32'(POP_VALID), 0);

    // source block cut short by the controller's EOP
    repeat (5) push_byte(8'($urandom));
    start_blk(1'b0, 16'd5);
    dma_xfer(8'h00);
    dma_xfer(8'h00);
    EOP_N_IN = 1'b0;
    step();
    EOP_N_IN = 1'b1;
    chk("eop_in_done", 32'(DONE), 1);
    chk("eop_in_tc", 32'(TC), 0);
    step();
    chk("eop_in_idle", 32'(BUSY), 0);
    chk("eop_in_left", 32'(mq.size()), 3);
    repeat (3) pop_byte();
    chk("eop_fifo_empty", 32'(POP_VALID), 0);

    // DACK without strobe, then both strobes low: neither may commit
    b1 = 8'($urandom);
    push_byte(b1);
    push_byte(~b1);
    start_blk(1'b0, 16'd2);
    wait_dreq("dreq_abort", 40);
    DACK = 1'b1;
    step();
    DACK = 1'b0;
    step();
    step();
    chk("dreq_back", 32'(DREQ), 1);
    chk("abort_no_pop", 32'(POP_DATA), 32'(b1));
    DACK = 1'b1;
    step();
    IOR_N = 1'b0;
    IOW_N = 1'b0;
    step();
    chk("err_set", 32'(ERR), 1);
    IOR_N = 1'b1;
    IOW_N = 1'b1;
    step();
    DACK = 1'b0;
    step();
    step();
    chk("both_no_pop", 32'(POP_DATA), 32'(b1));
    chk("both_busy", 32'(BUSY), 1);
    dma_xfer(8'h00);
    dma_xfer(8'h00);
    chk("err_sticky", 32'(ERR), 1);

    // reset in the middle of a read strobe
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    start_blk(1'b0, 16'd2);
    wait_dreq("dreq_rst", 40);
    DACK = 1'b1;
    step();
    IOR_N = 1'b0;
    step();
    RESET = 1'b1;
    step();
    check_reset_outputs("midrst");
    mq.delete();
    rem = 0;
    RESET = 1'b0;
    IOR_N = 1'b1;
    DACK = 1'b0;
    step();
    chk("midrst_no_done", 32'(DONE), 0);

    // zero-length start is ignored
    start_blk(1'b0, 16'd0);
    step();
    chk("zero_len_idle", 32'(BUSY), 0);

    // random blocks
    for (int blk = 0; blk < 8; blk++) begin
      d = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      if (!d) for (int i = 0; i < len; i++) push_byte(8'($urandom));
      start_blk(d, CNT_W'(len));
      for (int i = 0; i < len; i++) dma_xfer(8'($urandom));
      if (d) for (int i = 0; i < len; i++) pop_byte();
      chk("rand_fifo_empty", 32'(POP_VALID), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
